// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: field encodings, ALU command
// enum, control bundle and the ARM condition-code evaluator.
package id_pkg;

  localparam int NUM_REGS = 16;

  localparam logic [1:0] MODE_ARITH  = 2'b00;
  localparam logic [1:0] MODE_MEM    = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  typedef struct packed {
    logic     wb;
    logic     mem_r;
    logic     mem_w;
    exe_cmd_t exe_cmd;
    logic     b;
    logic     s;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{wb: 1'b0, mem_r: 1'b0, mem_w: 1'b0,
                                 exe_cmd: EXE_NOP, b: 1'b0, s: 1'b0};

  // sr is {N,Z,C,V}; code 1111 never passes.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
    logic n, z, c, v;
    {n, z, c, v} = sr;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~c | z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = ~z & (n == v);
      COND_LE: cond_check = z | (n != v);
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipelined_regfile.sv
// 16-entry register file with NUM_WB write ports and two combinational read
// ports; the highest-index write port wins on both commit and bypass.
module regfile_mwp
  import id_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_WB    = 1,
  parameter int WB_BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [4*NUM_WB-1:0]      wb_dest,
  input  logic [DATA_W*NUM_WB-1:0] wb_value,
  input  logic [3:0]               rd_idx1,
  input  logic [3:0]               rd_idx2,
  output logic [DATA_W-1:0]        rd_data1,
  output logic [DATA_W-1:0]        rd_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Ports are visited in ascending order so the last (highest) enabled port
  // targeting an index is the one that lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_en[k]) regs[wb_dest[4*k +: 4]] <= wb_value[DATA_W*k +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_data1 = regs[rd_idx1];
    rd_data2 = regs[rd_idx2];
    if (WB_BYPASS != 0) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_en[k] && (wb_dest[4*k +: 4] == rd_idx1)) rd_data1 = wb_value[DATA_W*k +: DATA_W];
        if (wb_en[k] && (wb_dest[4*k +: 4] == rd_idx2)) rd_data2 = wb_value[DATA_W*k +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: control decode, condition check, register read with
// write-through bypass, and the ID/EX pipeline register toward EXE.
module id_stage_pipelined
  import id_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int NUM_WB      = 1,
  parameter int WB_BYPASS   = 1,
  parameter int COND_BUBBLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [PC_W-1:0]          if_pc,
  input  logic [31:0]              instruction,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [4*NUM_WB-1:0]      wb_dest,
  input  logic [DATA_W*NUM_WB-1:0] wb_value,
  input  logic [3:0]               sr,
  input  logic                     hazard,
  input  logic                     flush,
  input  logic                     ex_hold,
  output logic                     id_ready,
  output logic [3:0]               src1,
  output logic [3:0]               src2,
  output logic                     two_src,
  output logic                     ex_valid,
  output logic                     ex_cond_ok,
  output logic                     ex_wb_en,
  output logic                     ex_mem_r_en,
  output logic                     ex_mem_w_en,
  output logic                     ex_b,
  output logic                     ex_s,
  output logic [3:0]               ex_exe_cmd,
  output logic [DATA_W-1:0]        ex_val_rn,
  output logic [DATA_W-1:0]        ex_val_rm,
  output logic                     ex_imm,
  output logic [11:0]              ex_shift_operand,
  output logic [23:0]              ex_signed_imm_24,
  output logic [3:0]               ex_dest,
  output logic [3:0]               ex_src1,
  output logic [3:0]               ex_src2,
  output logic [PC_W-1:0]          ex_pc
);

  logic [3:0]        cond;
  logic [1:0]        mode;
  logic [3:0]        opcode;
  logic              s_bit;
  logic              mem_write;
  logic              cond_pass;
  logic              bubble;
  ctrl_t             ctrl;
  ctrl_t             ex_ctrl;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;

  assign cond      = instruction[31:28];
  assign mode      = instruction[27:26];
  assign opcode    = instruction[24:21];
  assign s_bit     = instruction[20];
  assign mem_write = (mode == MODE_MEM) & ~s_bit;
  assign cond_pass = cond_check(cond, sr);

  // Handshake: IF may present a new instruction only while id_ready=1;
  // ex_valid=1 marks a real instruction in ID/EX, ex_valid=0 a bubble.
  assign id_ready = ~hazard & ~ex_hold;
  assign src1     = instruction[19:16];
  assign src2     = mem_write ? instruction[15:12] : instruction[3:0];
  assign two_src  = ~instruction[25] | mem_write;
  assign bubble   = flush | hazard | ~if_valid;

  always_comb begin
    ctrl = CTRL_NOP;
    case (mode)
      MODE_ARITH: begin
        ctrl.wb = 1'b1;
        ctrl.s  = s_bit;
        case (opcode)
          OP_MOV: ctrl.exe_cmd = EXE_MOV;
          OP_MVN: ctrl.exe_cmd = EXE_MVN;
          OP_ADD: ctrl.exe_cmd = EXE_ADD;
          OP_ADC: ctrl.exe_cmd = EXE_ADC;
          OP_SUB: ctrl.exe_cmd = EXE_SUB;
          OP_SBC: ctrl.exe_cmd = EXE_SBC;
          OP_AND: ctrl.exe_cmd = EXE_AND;
          OP_ORR: ctrl.exe_cmd = EXE_ORR;
          OP_EOR: ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl.exe_cmd = EXE_SUB;
            ctrl.wb      = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd = EXE_AND;
            ctrl.wb      = 1'b0;
          end
          default: ctrl = CTRL_NOP;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.mem_r   = s_bit;
        ctrl.wb      = s_bit;
        ctrl.mem_w   = ~s_bit;
      end
      MODE_BRANCH: ctrl.b = 1'b1;
      default: ctrl = CTRL_NOP;
    endcase
  end

  regfile_mwp #(
    .DATA_W    (DATA_W),
    .NUM_WB    (NUM_WB),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .wb_en    (wb_en),
    .wb_dest  (wb_dest),
    .wb_value (wb_value),
    .rd_idx1  (src1),
    .rd_idx2  (src2),
    .rd_data1 (val_rn),
    .rd_data2 (val_rm)
  );

  // A flush arriving during ex_hold is dropped here; the hazard unit keeps
  // flush asserted until the hold releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_cond_ok       <= 1'b0;
      ex_ctrl          <= CTRL_NOP;
      ex_val_rn        <= '0;
      ex_val_rm        <= '0;
      ex_imm           <= 1'b0;
      ex_shift_operand <= '0;
      ex_signed_imm_24 <= '0;
      ex_dest          <= '0;
      ex_src1          <= '0;
      ex_src2          <= '0;
      ex_pc            <= '0;
    end else if (!ex_hold) begin
      ex_val_rn        <= val_rn;
      ex_val_rm        <= val_rm;
      ex_imm           <= instruction[25];
      ex_shift_operand <= instruction[11:0];
      ex_signed_imm_24 <= instruction[23:0];
      ex_dest          <= instruction[15:12];
      ex_src1          <= src1;
      ex_src2          <= src2;
      ex_pc            <= if_pc;
      if (bubble) begin
        ex_valid   <= 1'b0;
        ex_cond_ok <= 1'b0;
        ex_ctrl    <= CTRL_NOP;
      end else begin
        ex_valid   <= 1'b1;
        ex_cond_ok <= cond_pass;
        ex_ctrl    <= (cond_pass || (COND_BUBBLE == 0)) ? ctrl : CTRL_NOP;
      end
    end
  end

  assign ex_wb_en    = ex_ctrl.wb;
  assign ex_mem_r_en = ex_ctrl.mem_r;
  assign ex_mem_w_en = ex_ctrl.mem_w;
  assign ex_b        = ex_ctrl.b;
  assign ex_s        = ex_ctrl.s;
  assign ex_exe_cmd  = ex_ctrl.exe_cmd;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: two instances (bypass+cond-bubble, and
// no-bypass+cond-pass-through) against a behavioural model of the stage.
module tb_id_stage_pipelined;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int NW = 2;

  typedef struct packed {
    logic          valid;
    logic          cond_ok;
    logic          wb;
    logic          mem_r;
    logic          mem_w;
    logic          b;
    logic          s;
    logic [3:0]    cmd;
    logic [DW-1:0] rn;
    logic [DW-1:0] rm;
    logic          imm;
    logic [11:0]   shift;
    logic [23:0]   simm;
    logic [3:0]    dest;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [PW-1:0] pc;
  } exp_t;

  localparam int EW = $bits(exp_t);

  logic             clk = 1'b0;
  logic             reset;
  logic             if_valid;
  logic [PW-1:0]    if_pc;
  logic [31:0]      instruction;
  logic [NW-1:0]    wb_en;
  logic [4*NW-1:0]  wb_dest;
  logic [DW*NW-1:0] wb_value;
  logic [3:0]       sr;
  logic             hazard, flush, ex_hold;

  logic id_ready_a, two_src_a, ex_valid_a, ex_cond_ok_a, ex_wb_en_a, ex_mem_r_en_a;
  logic ex_mem_w_en_a, ex_b_a, ex_s_a, ex_imm_a;
  logic [3:0] src1_a, src2_a, ex_exe_cmd_a, ex_dest_a, ex_src1_a, ex_src2_a;
  logic [DW-1:0] ex_val_rn_a, ex_val_rm_a;
  logic [11:0] ex_shift_operand_a;
  logic [23:0] ex_signed_imm_24_a;
  logic [PW-1:0] ex_pc_a;

  logic id_ready_b, two_src_b, ex_valid_b, ex_cond_ok_b, ex_wb_en_b, ex_mem_r_en_b;
  logic ex_mem_w_en_b, ex_b_b, ex_s_b, ex_imm_b;
  logic [3:0] src1_b, src2_b, ex_exe_cmd_b, ex_dest_b, ex_src1_b, ex_src2_b;
  logic [DW-1:0] ex_val_rn_b, ex_val_rm_b;
  logic [11:0] ex_shift_operand_b;
  logic [23:0] ex_signed_imm_24_b;
  logic [PW-1:0] ex_pc_b;

  id_stage_pipelined #(.DATA_W(DW), .PC_W(PW), .NUM_WB(NW), .WB_BYPASS(1), .COND_BUBBLE(1)) dut_a (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .instruction(instruction),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .sr(sr), .hazard(hazard),
    .flush(flush), .ex_hold(ex_hold), .id_ready(id_ready_a), .src1(src1_a), .src2(src2_a),
    .two_src(two_src_a), .ex_valid(ex_valid_a), .ex_cond_ok(ex_cond_ok_a), .ex_wb_en(ex_wb_en_a),
    .ex_mem_r_en(ex_mem_r_en_a), .ex_mem_w_en(ex_mem_w_en_a), .ex_b(ex_b_a), .ex_s(ex_s_a),
    .ex_exe_cmd(ex_exe_cmd_a), .ex_val_rn(ex_val_rn_a), .ex_val_rm(ex_val_rm_a), .ex_imm(ex_imm_a),
    .ex_shift_operand(ex_shift_operand_a), .ex_signed_imm_24(ex_signed_imm_24_a),
    .ex_dest(ex_dest_a), .ex_src1(ex_src1_a), .ex_src2(ex_src2_a), .ex_pc(ex_pc_a));

  id_stage_pipelined #(.DATA_W(DW), .PC_W(PW), .NUM_WB(NW), .WB_BYPASS(0), .COND_BUBBLE(0)) dut_b (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .instruction(instruction),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .sr(sr), .hazard(hazard),
    .flush(flush), .ex_hold(ex_hold), .id_ready(id_ready_b), .src1(src1_b), .src2(src2_b),
    .two_src(two_src_b), .ex_valid(ex_valid_b), .ex_cond_ok(ex_cond_ok_b), .ex_wb_en(ex_wb_en_b),
    .ex_mem_r_en(ex_mem_r_en_b), .ex_mem_w_en(ex_mem_w_en_b), .ex_b(ex_b_b), .ex_s(ex_s_b),
    .ex_exe_cmd(ex_exe_cmd_b), .ex_val_rn(ex_val_rn_b), .ex_val_rm(ex_val_rm_b), .ex_imm(ex_imm_b),
    .ex_shift_operand(ex_shift_operand_b), .ex_signed_imm_24(ex_signed_imm_24_b),
    .ex_dest(ex_dest_b), .ex_src1(ex_src1_b), .ex_src2(ex_src2_b), .ex_pc(ex_pc_b));

  exp_t obs_a, obs_b;
  assign obs_a = {ex_valid_a, ex_cond_ok_a, ex_wb_en_a, ex_mem_r_en_a, ex_mem_w_en_a, ex_b_a,
                  ex_s_a, ex_exe_cmd_a, ex_val_rn_a, ex_val_rm_a, ex_imm_a, ex_shift_operand_a,
                  ex_signed_imm_24_a, ex_dest_a, ex_src1_a, ex_src2_a, ex_pc_a};
  assign obs_b = {ex_valid_b, ex_cond_ok_b, ex_wb_en_b, ex_mem_r_en_b, ex_mem_w_en_b, ex_b_b,
                  ex_s_b, ex_exe_cmd_b, ex_val_rn_b, ex_val_rm_b, ex_imm_b, ex_shift_operand_b,
                  ex_signed_imm_24_b, ex_dest_b, ex_src1_b, ex_src2_b, ex_pc_b};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  exp_t cur_a, cur_b;
  logic [DW-1:0] mregs [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // returns {known, wb, cmd} for the data-processing opcode table
  function automatic logic [5:0] model_alu(input logic [3:0] op);
    case (op)
      4'b1101: return 6'b11_0001;
      4'b1111: return 6'b11_1001;
      4'b0100: return 6'b11_0010;
      4'b0101: return 6'b11_0011;
      4'b0010: return 6'b11_0100;
      4'b0110: return 6'b11_0101;
      4'b0000: return 6'b11_0110;
      4'b1100: return 6'b11_0111;
      4'b0001: return 6'b11_1000;
      4'b1010: return 6'b10_0100;
      4'b1000: return 6'b10_0110;
      default: return 6'b00_0000;
    endcase
  endfunction

  function automatic logic model_store();
    return (instruction[27:26] == 2'b01) && !instruction[20];
  endfunction

  function automatic logic [3:0] model_src2();
    return model_store() ? instruction[15:12] : instruction[3:0];
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [3:0] idx, input bit bypass);
    logic [DW-1:0] v;
    v = mregs[idx];
    if (bypass)
      for (int k = 0; k < NW; k++)
        if (wb_en[k] && wb_dest[4*k +: 4] == idx) v = wb_value[DW*k +: DW];
    return v;
  endfunction

  function automatic exp_t model_next(input exp_t cur, input bit bypass, input bit cbub);
    exp_t n;
    logic ok;
    logic [5:0] alu;
    if (ex_hold) return cur;
    n       = '0;
    n.s1    = instruction[19:16];
    n.s2    = model_src2();
    n.rn    = model_read(n.s1, bypass);
    n.rm    = model_read(n.s2, bypass);
    n.imm   = instruction[25];
    n.shift = instruction[11:0];
    n.simm  = instruction[23:0];
    n.dest  = instruction[15:12];
    n.pc    = if_pc;
    if (flush || hazard || !if_valid) return n;
    n.valid   = 1'b1;
    ok        = model_cond(instruction[31:28], sr);
    n.cond_ok = ok;
    if (ok || !cbub) begin
      case (instruction[27:26])
        2'b00: begin
          alu = model_alu(instruction[24:21]);
          if (alu[5]) begin
            n.wb  = alu[4];
            n.cmd = alu[3:0];
            n.s   = instruction[20];
          end
        end
        2'b01: begin
          n.cmd   = 4'b0010;
          n.mem_r = instruction[20];
          n.wb    = instruction[20];
          n.mem_w = !instruction[20];
        end
        2'b10: n.b = 1'b1;
        default: ;
      endcase
    end
    return n;
  endfunction

  task automatic model_commit();
    for (int k = 0; k < NW; k++)
      if (wb_en[k]) mregs[wb_dest[4*k +: 4]] = wb_value[DW*k +: DW];
  endtask

  task automatic compare_ex(input string who, input exp_t o, input exp_t e);
    check_eq({who, ".ctrl"}, {o.valid, o.wb, o.mem_r, o.mem_w, o.b, o.s, o.cmd},
             {e.valid, e.wb, e.mem_r, e.mem_w, e.b, e.s, e.cmd});
    if (e.valid) begin
      check_eq({who, ".cond_ok"}, o.cond_ok, e.cond_ok);
      check_eq({who, ".val_rn"}, o.rn, e.rn);
      check_eq({who, ".val_rm"}, o.rm, e.rm);
      check_eq({who, ".imm_fields"}, {o.imm, o.shift, o.simm}, {e.imm, e.shift, e.simm});
      check_eq({who, ".indices"}, {o.dest, o.s1, o.s2}, {e.dest, e.s1, e.s2});
      check_eq({who, ".pc"}, o.pc, e.pc);
    end
  endtask

  task automatic check_all_zero(input string who, input exp_t o);
    check_eq({who, ".zero_lo"}, o[63:0], 64'd0);
    check_eq({who, ".zero_mid"}, o[127:64], 64'd0);
    check_eq({who, ".zero_hi"}, 64'(o[EW-1:128]), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    #1;
    check_eq("a.id_ready", id_ready_a, !hazard && !ex_hold);
    check_eq("b.id_ready", id_ready_b, !hazard && !ex_hold);
    check_eq("a.src", {src1_a, src2_a, two_src_a},
             {instruction[19:16], model_src2(), !instruction[25] || model_store()});
    check_eq("b.src", {src1_b, src2_b, two_src_b},
             {instruction[19:16], model_src2(), !instruction[25] || model_store()});
    exp_q_a.push_back(model_next(cur_a, 1'b1, 1'b1));
    exp_q_b.push_back(model_next(cur_b, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    cur_a = exp_q_a.pop_front();
    cur_b = exp_q_b.pop_front();
    compare_ex("a", obs_a, cur_a);
    compare_ex("b", obs_b, cur_b);
    model_commit();
  endtask

  task automatic clear_inputs();
    if_valid = 1'b0; if_pc = '0; instruction = '0; wb_en = '0; wb_dest = '0;
    wb_value = '0; sr = '0; hazard = 1'b0; flush = 1'b0; ex_hold = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    cur_a = '0;
    cur_b = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check_all_zero("a.por", obs_a);
    check_all_zero("b.por", obs_b);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R3 = 0xAA, then ADD R1,R3,R3
    wb_en = 2'b01; wb_dest = {4'd0, 4'd3}; wb_value = {32'h0, 32'hAA};
    step();
    wb_en = '0; if_valid = 1'b1; instruction = 32'hE0831003; if_pc = 32'h100;
    step();
    check_eq("add.cmd", ex_exe_cmd_a, 4'b0010);
    check_eq("add.wb", ex_wb_en_a, 1'b1);
    check_eq("add.rn", ex_val_rn_a, 32'hAA);
    check_eq("add.rm", ex_val_rm_a, 32'hAA);
    check_eq("add.dest", ex_dest_a, 4'd1);

    // Both ports write R5 in the same cycle that ADD R0,R5,R5 decodes
    wb_en = 2'b11; wb_dest = {4'd5, 4'd5}; wb_value = {32'h22, 32'h11};
    instruction = 32'hE0850005;
    step();
    check_eq("same_dest.bypass_rn", ex_val_rn_a, 32'h22);
    check_eq("same_dest.nobypass_rn", ex_val_rn_b, 32'h0);
    wb_en = '0;
    step();
    check_eq("same_dest.later_a", ex_val_rn_a, 32'h22);
    check_eq("same_dest.later_b", ex_val_rn_b, 32'h22);

    // EQ condition with Z clear, then set
    instruction = 32'h00831003; sr = 4'b0000;
    step();
    check_eq("eq_fail.a", {ex_valid_a, ex_cond_ok_a, ex_wb_en_a, ex_exe_cmd_a}, {3'b100, 4'b0000});
    check_eq("eq_fail.b", {ex_valid_b, ex_cond_ok_b, ex_wb_en_b, ex_exe_cmd_b}, {3'b101, 4'b0010});
    sr = 4'b0100;
    step();
    check_eq("eq_pass.a", {ex_valid_a, ex_cond_ok_a, ex_wb_en_a, ex_exe_cmd_a}, {3'b111, 4'b0010});

    // STR R2,[R4] under hazard, then released
    instruction = 32'hE5842000; sr = 4'b0000; hazard = 1'b1;
    #1;
    check_eq("str.id_ready", id_ready_a, 1'b0);
    check_eq("str.src2", src2_a, 4'd2);
    check_eq("str.two_src", two_src_a, 1'b1);
    step();
    check_eq("str.bubble", ex_valid_a, 1'b0);
    hazard = 1'b0;
    step();
    check_eq("str.mem_w", {ex_valid_a, ex_mem_w_en_a}, 2'b11);

    // Hold for three cycles with a different instruction waiting
    instruction = 32'hE0850005; ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold.frozen", {ex_mem_w_en_a, ex_src1_a, ex_src2_a}, {1'b1, 4'd4, 4'd2});
    end
    ex_hold = 1'b0; flush = 1'b1; hazard = 1'b1;
    step();
    check_eq("flush_hazard.bubble", ex_valid_a, 1'b0);
    flush = 1'b0; hazard = 1'b0;

    // Asynchronous reset while a valid instruction sits in ID/EX
    step();
    check_eq("pre_reset.valid", ex_valid_a, 1'b1);
    reset = 1'b1;
    #1;
    check_all_zero("a.async_reset", obs_a);
    check_all_zero("b.async_reset", obs_b);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("a.reset_held", obs_a);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if_valid    = ($urandom_range(0, 9) != 0);
      instruction = $urandom;
      if ($urandom_range(0, 3) != 0) instruction[31:28] = 4'hE;
      if_pc    = $urandom;
      sr       = 4'($urandom_range(0, 15));
      hazard   = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      ex_hold  = ($urandom_range(0, 7) == 0);
      wb_en    = 2'($urandom_range(0, 3));
      wb_dest  = 8'($urandom_range(0, 255));
      wb_value = {$urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
